// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle shared by the fetch port, the MEM data port and the external bus bridge.
// The "master" view belongs to the arbiter; "slave" is the view of the core and bridge.
interface mem_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_sel;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;

    logic        stall_if;
    logic        stall_mem;

    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_sel;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_sel, data_size, data_addr, data_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_rdata, inst_ready, data_rdata, data_ready,
        output stall_if, stall_mem,
        output bus_req, bus_wr, bus_sel, bus_size, bus_addr, bus_wdata
    );

    modport slave (
        output inst_req, inst_addr,
        output data_req, data_wr, data_sel, data_size, data_addr, data_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_rdata, inst_ready, data_rdata, data_ready,
        input  stall_if, stall_mem,
        input  bus_req, bus_wr, bus_sel, bus_size, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and the MEM-stage data port.
// Define ARB_STARVE_GUARD_EN to let fetch win a grant after STARVE_LIMIT data grants in a row.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_bus_arbiter: STARVE_LIMIT must be within 1..15");
    end

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        inst_ready_q, inst_ready_d;
    logic        data_ready_q, data_ready_d;

    logic        inst_pend;
    logic        data_pend;
    logic        starve_hit;
    logic        grant_inst;
    logic        grant_data;
    logic        complete;

    // A requester whose ready pulse is out this cycle is still holding req; ignore it to avoid reissue.
    assign inst_pend = bus.inst_req & ~inst_ready_q;
    assign data_pend = bus.data_req & ~data_ready_q;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = (starve_cnt_q == 4'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_inst) begin
            starve_cnt_d = 4'd0;
        end else if (grant_data && inst_pend && starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == ST_IDLE) begin
            if (data_pend && !(inst_pend && starve_hit)) begin
                grant_data = 1'b1;
            end else if (inst_pend) begin
                grant_inst = 1'b1;
            end
        end
    end

    assign complete = ((state_q == ST_ADDR) && bus.bus_addr_ok && bus.bus_data_ok) ||
                      ((state_q == ST_DATA) && bus.bus_data_ok);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        sel_d        = sel_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    state_d = ST_ADDR;
                    owner_d = OWN_DATA;
                    wr_d    = bus.data_wr;
                    sel_d   = bus.data_wr ? bus.data_sel : 4'b0000;
                    size_d  = bus.data_size;
                    addr_d  = bus.data_addr;
                    wdata_d = bus.data_wdata;
                end else if (grant_inst) begin
                    state_d = ST_ADDR;
                    owner_d = OWN_INST;
                    wr_d    = 1'b0;
                    sel_d   = 4'b0000;
                    size_d  = 2'd2;
                    addr_d  = bus.inst_addr;
                    wdata_d = 32'd0;
                end
            end
            ST_ADDR: begin
                if (bus.bus_addr_ok) begin
                    state_d = bus.bus_data_ok ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.bus_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stores leave the load data register untouched.
        if (complete) begin
            owner_d = OWN_NONE;
            if (owner_q == OWN_INST) begin
                inst_ready_d = 1'b1;
                inst_rdata_d = bus.bus_rdata;
            end else if (owner_q == OWN_DATA) begin
                data_ready_d = 1'b1;
                if (!wr_q) begin
                    data_rdata_d = bus.bus_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            wr_q         <= 1'b0;
            sel_q        <= 4'd0;
            size_q       <= 2'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            sel_q        <= sel_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign bus.bus_req    = (state_q == ST_ADDR);
    assign bus.bus_wr     = wr_q;
    assign bus.bus_sel    = sel_q;
    assign bus.bus_size   = size_q;
    assign bus.bus_addr   = addr_q;
    assign bus.bus_wdata  = wdata_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.inst_ready = inst_ready_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.data_ready = data_ready_q;
    assign bus.stall_if   = inst_pend;
    assign bus.stall_mem  = data_pend;

endmodule
